// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

   // One fetched instruction paired with the address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch unit, the instruction ROM, the redirect source
// and decode.
//
// Handshake: decode sees a transfer in every cycle where out_valid && out_ready
// are both high at the rising edge. While out_valid is high and out_ready is
// low, out_pc/out_inst hold still until the transfer or a redirect. out_valid
// never depends on out_ready. The ROM side has no handshake: imem_inst always
// carries the word for the imem_addr of the previous cycle.
interface fetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   modport master (
      output imem_addr, out_valid, out_pc, out_inst,
      input  imem_inst, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_pc, out_inst,
      output imem_inst, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO of fetched instructions. The head is read through a
// combinational mux so a buffered entry is visible in the same cycle it heads
// the queue. Flush empties the queue and overrides push and pop.
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_data,
   output logic [1:0]   o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;

   // Pointer and occupancy bookkeeping; push and pop may coincide.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   // Storage write; payload needs no reset because occupancy guards it.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush && i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives the synchronous ROM,
// pairs each returned word with its PC and presents it to decode. A redirect
// flushes all buffered and in-flight work and restarts at the new target.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   fetch_if.master    bus,
   output logic [1:0] o_dbg_count
);

   logic [31:0]  r_pc;
   logic         r_req_valid;
   logic [31:0]  r_req_pc;

   logic [1:0]   w_count;
   fetch_entry_t w_head;
   fetch_entry_t w_present;
   logic [31:0]  w_target;
   logic         w_redirect;
   logic         w_out_valid;
   logic         w_pop;
   logic         w_fall_through;
   logic         w_push;
   logic         w_fifo_pop;
   logic [2:0]   w_occ_next;
   logic         w_issue;

   assign w_redirect = bus.redirect_valid;
   assign w_target   = {bus.redirect_pc[31:2], 2'b00};

   // Something is presentable whenever the FIFO holds an entry or a response
   // is arriving; a redirect or reset hides it so no handshake can happen.
   assign w_out_valid    = !rst && !w_redirect && ((w_count != 2'd0) || r_req_valid);
   assign w_pop          = w_out_valid && bus.out_ready;
   assign w_fall_through = (w_count == 2'd0) && r_req_valid;
   assign w_fifo_pop     = w_pop && (w_count != 2'd0);
   assign w_push         = r_req_valid && !w_redirect && !rst && !(w_fall_through && w_pop);

   // Slots committed after this cycle; a new read may only start if it fits.
   assign w_occ_next = {1'b0, w_count} + {2'b00, r_req_valid} - {2'b00, w_pop};
   assign w_issue    = w_redirect || (w_occ_next < 3'd2);

   // Present the FIFO head, else the response falling straight through.
   always_comb begin
      w_present = '0;
      if (w_count != 2'd0) begin
         w_present = w_head;
      end else begin
         w_present.pc   = r_req_pc;
         w_present.inst = bus.imem_inst;
      end
   end

   // Drive the ROM address and decode outputs; payload is zero when idle.
   always_comb begin
      bus.imem_addr = r_pc;
      if (rst) begin
         bus.imem_addr = RESET_PC;
      end else if (w_redirect) begin
         bus.imem_addr = w_target;
      end
      bus.out_valid = w_out_valid;
      bus.out_pc    = w_out_valid ? w_present.pc   : 32'h0;
      bus.out_inst  = w_out_valid ? w_present.inst : 32'h0;
   end

   // PC and in-flight tracking; redirect beats the normal issue rule.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_req_valid <= 1'b0;
         r_req_pc    <= 32'h0;
      end else if (w_redirect) begin
         r_pc        <= w_target + INST_BYTES;
         r_req_valid <= 1'b1;
         r_req_pc    <= w_target;
      end else if (w_issue) begin
         r_pc        <= r_pc + INST_BYTES;
         r_req_valid <= 1'b1;
         r_req_pc    <= r_pc;
      end else begin
         r_req_valid <= 1'b0;
      end
   end

   fetch_skid_fifo u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_fifo_pop),
      .i_flush (w_redirect),
      .i_data  ({r_req_pc, bus.imem_inst}),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign o_dbg_count = w_count;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator for the core: owns the PC and drives the byte address into the synchronous-read instruction ROM, which returns the word one clock later. It pairs each returned word with its PC and hands it to decode over a valid/ready handshake. A 2-entry skid buffer absorbs decode stalls without losing in-flight reads. A redirect port (branch/jump) flushes everything and restarts fetch.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to the instruction memory; the word appears on imem_inst the next cycle.
- imem_inst  in  32  word for the address driven in the previous cycle.
- redirect_valid  in  1  restart fetch at redirect_pc this cycle.
- redirect_pc  in  32  new PC; bits [1:0] are ignored (forced 0).
- out_valid  out  1  out_pc/out_inst hold a fetched instruction.
- out_ready  in  1  decode accepts this cycle.
- out_pc  out  32  PC of the presented instruction.
- out_inst  out  32  presented instruction word.

## Operation
- State:
  - pc: next address to issue.
  - req_valid_q/req_pc_q: a fetch issued last cycle whose data is on imem_inst now.
  - 2-entry FIFO of {pc, inst}, count 0..2.
- The memory reads every non-reset cycle. A cycle "issues" only if the unit marks it as in flight; unissued reads are ignored.
- pop = out_valid && out_ready.
- Issue rule without redirect: issue iff count + req_valid_q − pop < 2.
  - On issue: imem_addr = pc, pc <= pc + 4 (wraps mod 2^32), req_valid_q <= 1, req_pc_q <= pc.
  - With no issue, imem_addr = pc and req_valid_q <= 0.
- Presentation:
  - count > 0: present the FIFO head.
  - count == 0 and req_valid_q: fall through, presenting req_pc_q/imem_inst directly.
  - Otherwise out_valid = 0.
- Capture: a response (req_valid_q = 1) is pushed at the FIFO tail unless it is consumed by fall-through in the same cycle. Pop and push in the same cycle is allowed. Order is strictly preserved.
- Redirect (redirect_valid = 1 in cycle R), highest priority:
  - out_valid = 0 in R, so no handshake occurs in R.
  - The FIFO is flushed and the response arriving in R is dropped.
  - imem_addr = {redirect_pc[31:2], 2'b00} combinationally, pc <= that + 4, req_valid_q <= 1, req_pc_q <= redirect target.
- out_pc/out_inst = 0 whenever out_valid = 0.
- While out_valid && !out_ready and no redirect, out_pc/out_inst stay stable.

## Timing
- Reset (rst = 1):
  - Registers: pc <= RESET_PC, req_valid_q <= 0, count <= 0.
  - Outputs: out_valid = 0, out_pc = 0, out_inst = 0, imem_addr = RESET_PC.
- First fetch: the first cycle with rst = 0 (C0) issues RESET_PC. out_valid = 1 with out_pc = RESET_PC in C1.
- Fetch-to-present latency is 1 cycle (fall-through). Throughput is 1 instr/cycle with out_ready held high.
- Redirect in R: the target is presented in R+1, then target+4 in R+2 if accepted.
- Stall: at most 2 entries buffered plus 0 in flight. Issue resumes in the same cycle the first pop occurs.
- Simultaneous redirect and full FIFO: the flush wins; the target is still issued in R.
- Reset asserted mid-operation: the next cycle matches the post-reset state exactly. In-flight data is discarded.

## Structure
- Package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}
  - localparam INST_BYTES = 4.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Synchronous active-high reset on rst.
- Issue, redirect and presentation logic live in fetch_unit. The FIFO read mux is combinational.

## Test plan
- Reset release, out_ready = 1, ROM word i = 0x1000_0000 + i -> out_valid from C1; (out_pc, out_inst) = (0x0, 0x1000_0000), (0x4, 0x1000_0001), … every cycle.
- out_ready low for 5 cycles starting at out_pc = 0x8 -> FIFO holds 0x8 and 0xC; imem_addr issues stop. Release -> presented sequence continues 0x8, 0xC, 0x10 with no gaps, duplicates or losses.
- redirect_valid with redirect_pc = 0x43 while FIFO is full -> out_valid = 0 that cycle, imem_addr = 0x40. Next cycle out_pc = 0x40; 0x8/0xC are never presented.
- Redirect on the same cycle as an accepted fall-through -> no handshake counted that cycle; the target follows next cycle.
- rst pulsed mid-stream with count = 2 -> out_valid = 0 during rst. After release, re-fetch from RESET_PC = 0x100 (parameter override).
- pc = 0xFFFF_FFFC sequential fetch -> the next out_pc is 0x0000_0000.
